// File: rtl/eth_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arb_if
// Brief    : Request/grant and TX-path handshake bundle for eth_tx_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface eth_tx_arb_if #(
    parameter int NUM_REQ = 3
) ();
    localparam int c_SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [c_SEL_W-1:0] tx_sel;
    logic               tx_start;
    logic               tx_done;
    logic               tx_busy;
    logic               timeout_err;

    modport master (
        input  req,
        input  tx_done,
        output grant,
        output tx_sel,
        output tx_start,
        output tx_busy,
        output timeout_err
    );

    modport slave (
        output req,
        output tx_done,
        input  grant,
        input  tx_sel,
        input  tx_start,
        input  tx_busy,
        input  timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/eth_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arb
// Brief    : Round-robin arbiter sharing one Ethernet TX path between sources,
//            with inter-frame gap. ETH_TX_ARB_TIMEOUT_EN adds a done watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arb #(
    parameter int NUM_REQ        = 3,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         aclk,
    input  logic         aresetn,
    eth_tx_arb_if.master bus
);
    localparam int c_SEL_W    = $clog2(NUM_REQ);
    localparam int c_SUM_W    = c_SEL_W + 1;
    localparam int c_GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int c_GAP_LOAD = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
    localparam logic [NUM_REQ-1:0] c_ONE = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || IFG_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("eth_tx_arb: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,    w_grant_nxt;
    logic [c_SEL_W-1:0] r_tx_sel,   w_tx_sel_nxt;
    logic               r_tx_start, w_tx_start_nxt;
    logic               r_tx_busy,  w_tx_busy_nxt;
    logic [c_SEL_W-1:0] r_rr_ptr,   w_rr_ptr_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt,  w_gap_cnt_nxt;
    logic [c_SEL_W-1:0] w_win;
    logic [c_SUM_W-1:0] w_arb_idx;
    logic [c_SEL_W-1:0] w_ptr_after;
    logic               w_wd_expire;

`ifdef ETH_TX_ARB_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_WD_W-1:0] r_wd_cnt, w_wd_cnt_nxt;
    logic              r_timeout_err, w_timeout_err_nxt;

    assign w_wd_expire     = (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = r_timeout_err;
`else
    assign w_wd_expire     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Scan from the highest index offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_win     = '0;
        w_arb_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_arb_idx = {1'b0, r_rr_ptr} + c_SUM_W'(i);
            if (w_arb_idx >= c_SUM_W'(NUM_REQ))
                w_arb_idx = w_arb_idx - c_SUM_W'(NUM_REQ);
            if (bus.req[w_arb_idx[c_SEL_W-1:0]])
                w_win = w_arb_idx[c_SEL_W-1:0];
        end
    end

    assign w_ptr_after = (r_tx_sel == c_SEL_W'(NUM_REQ - 1)) ? '0 : r_tx_sel + c_SEL_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_tx_sel_nxt      = r_tx_sel;
        w_tx_start_nxt    = 1'b0;
        w_tx_busy_nxt     = r_tx_busy;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_gap_cnt_nxt     = r_gap_cnt;
`ifdef ETH_TX_ARB_TIMEOUT_EN
        w_wd_cnt_nxt      = r_wd_cnt;
        w_timeout_err_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_grant_nxt    = c_ONE << w_win;
                    w_tx_sel_nxt   = w_win;
                    w_tx_start_nxt = 1'b1;
                    w_tx_busy_nxt  = 1'b1;
                    w_state_nxt    = ST_WAIT_DONE;
`ifdef ETH_TX_ARB_TIMEOUT_EN
                    w_wd_cnt_nxt   = '0;
`endif
                end
            end
            ST_WAIT_DONE: begin
                // A real done on the expiry cycle takes precedence over the watchdog.
                if (bus.tx_done || w_wd_expire) begin
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = w_ptr_after;
`ifdef ETH_TX_ARB_TIMEOUT_EN
                    w_timeout_err_nxt = !bus.tx_done;
`endif
                    if (IFG_CYCLES > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = c_GAP_W'(c_GAP_LOAD);
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_tx_busy_nxt = 1'b0;
                    end
                end else begin
`ifdef ETH_TX_ARB_TIMEOUT_EN
                    w_wd_cnt_nxt = r_wd_cnt + c_WD_W'(1);
`endif
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt   = ST_IDLE;
                    w_tx_busy_nxt = 1'b0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - c_GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_grant_nxt   = '0;
                w_tx_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_tx_sel      <= '0;
            r_tx_start    <= 1'b0;
            r_tx_busy     <= 1'b0;
            r_rr_ptr      <= '0;
            r_gap_cnt     <= '0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_tx_sel      <= w_tx_sel_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_tx_busy     <= w_tx_busy_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
`ifdef ETH_TX_ARB_TIMEOUT_EN
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
`endif
        end
    end

    assign bus.grant    = r_grant;
    assign bus.tx_sel   = r_tx_sel;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_busy  = r_tx_busy;
endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_arb
// Brief    : Directed self-checking bench for eth_tx_arb (3 sources, 12-cycle gap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arb;
    localparam int c_TO = 16;
`ifdef ETH_TX_ARB_TIMEOUT_EN
    localparam int c_LONG = 10;
`else
    localparam int c_LONG = 30;
`endif

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_starts = 0;
    int   cyc = 0;
    int   last_start = 0;

    eth_tx_arb_if #(.NUM_REQ(3)) bus ();

    eth_tx_arb #(
        .NUM_REQ        (3),
        .IFG_CYCLES     (12),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (bus.tx_start === 1'b1) n_starts <= n_starts + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick(2);
        aresetn = 1'b1;
    endtask

    // Drive tx_done k windows after the current one, then return in the first post-done window.
    task automatic frame(input int k);
        tick(k);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [2:0] exp_grant);
        int n = 0;
        while (bus.tx_start !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(bus.tx_start), 32'(1));
        check({tag, "_grant"}, 32'(bus.grant), 32'(exp_grant));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_g;
        bus.req     = 3'b000;
        bus.tx_done = 1'b0;

        // Reset and idle
        tick(2);
        check("rst_grant", 32'(bus.grant), 32'(0));
        check("rst_sel",   32'(bus.tx_sel), 32'(0));
        check("rst_start", 32'(bus.tx_start), 32'(0));
        check("rst_busy",  32'(bus.tx_busy), 32'(0));
        check("rst_to",    32'(bus.timeout_err), 32'(0));
        aresetn = 1'b1;
        tick(20);
        check("idle_grant",  32'(bus.grant), 32'(0));
        check("idle_busy",   32'(bus.tx_busy), 32'(0));
        check("idle_starts", 32'(n_starts), 32'(0));

        // Single request, long frame, gap length
        bus.req = 3'b010;
        tick();
        check("s_grant", 32'(bus.grant), 32'(3'b010));
        check("s_sel",   32'(bus.tx_sel), 32'(1));
        check("s_start", 32'(bus.tx_start), 32'(1));
        check("s_busy",  32'(bus.tx_busy), 32'(1));
        tick();
        bus.req = 3'b000;
        check("s_start_pulse", 32'(bus.tx_start), 32'(0));
        check("s_grant_hold",  32'(bus.grant), 32'(3'b010));
        frame(c_LONG - 1);
        check("s_done_grant", 32'(bus.grant), 32'(0));
        check("s_gap_busy0",  32'(bus.tx_busy), 32'(1));
        check("s_no_to",      32'(bus.timeout_err), 32'(0));
        tick(11);
        check("s_gap_busy11", 32'(bus.tx_busy), 32'(1));
        tick();
        check("s_gap_end",    32'(bus.tx_busy), 32'(0));

        // Fairness with all requesters active
        do_reset();
        bus.req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            exp_g = 3'b001 << (i % 3);
            wait_start($sformatf("rr%0d", i), exp_g);
            if (i > 0) check($sformatf("rr%0d_space", i), 32'(cyc - last_start), 32'(19));
            last_start = cyc;
            frame(5);
        end
        bus.req = 3'b000;

        // Request drop mid-frame and spurious done during the gap
        do_reset();
        bus.req = 3'b001;
        wait_start("drop", 3'b001);
        tick(3);
        bus.req = 3'b000;
        tick(3);
        check("drop_grant", 32'(bus.grant), 32'(3'b001));
        check("drop_sel",   32'(bus.tx_sel), 32'(0));
        frame(2);
        check("drop_done_grant", 32'(bus.grant), 32'(0));
        check("drop_done_busy",  32'(bus.tx_busy), 32'(1));
        bus.req = 3'b010;
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick(10);
        check("gap_idle_busy",  32'(bus.tx_busy), 32'(0));
        check("gap_idle_start", 32'(bus.tx_start), 32'(0));
        tick();
        check("gap_req_grant", 32'(bus.grant), 32'(3'b010));
        check("gap_req_start", 32'(bus.tx_start), 32'(1));
        check("gap_req_sel",   32'(bus.tx_sel), 32'(1));
        bus.req = 3'b000;
        frame(0);
        check("same_cyc_done_grant", 32'(bus.grant), 32'(0));
        check("same_cyc_done_busy",  32'(bus.tx_busy), 32'(1));

        // Wrap priority, reset mid-frame, pointer wrap
        bus.req = 3'b101;
        wait_start("wrap", 3'b100);
        tick(3);
        aresetn = 1'b0;
        tick();
        check("mid_rst_grant", 32'(bus.grant), 32'(0));
        check("mid_rst_busy",  32'(bus.tx_busy), 32'(0));
        check("mid_rst_start", 32'(bus.tx_start), 32'(0));
        aresetn = 1'b1;
        tick();
        check("post_rst_grant", 32'(bus.grant), 32'(3'b001));
        check("post_rst_sel",   32'(bus.tx_sel), 32'(0));
        frame(2);
        wait_start("rr_next", 3'b100);
        check("rr_next_sel", 32'(bus.tx_sel), 32'(2));
        frame(2);
        wait_start("rr_wrap", 3'b001);
        bus.req = 3'b000;
        frame(2);
        tick(14);

`ifdef ETH_TX_ARB_TIMEOUT_EN
        do_reset();
        bus.req = 3'b001;
        tick();
        check("to_start", 32'(bus.tx_start), 32'(1));
        tick(15);
        check("to_before", 32'(bus.timeout_err), 32'(0));
        check("to_hold",   32'(bus.grant), 32'(3'b001));
        tick();
        check("to_pulse",  32'(bus.timeout_err), 32'(1));
        check("to_grant",  32'(bus.grant), 32'(0));
        check("to_busy",   32'(bus.tx_busy), 32'(1));
        bus.req = 3'b011;
        tick();
        check("to_single", 32'(bus.timeout_err), 32'(0));
        wait_start("to_next", 3'b010);
        bus.req = 3'b000;
        frame(1);
        tick();
        check("total_starts", 32'(n_starts), 32'(15));
`else
        tick();
        check("total_starts", 32'(n_starts), 32'(13));
        check("to_tied", 32'(bus.timeout_err), 32'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Round-robin arbiter that shares the single Ethernet TX frame builder / MAC TX path between NUM_REQ frame sources (e.g. 0=ARP, 1=ICMP, 2=UDP).
- Grants one source at a time and issues a start pulse and source select to the TX path.
- Holds the grant until the TX path reports frame done, then enforces an inter-frame gap before the next arbitration.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- IFG_CYCLES, 12, idle cycles inserted after each frame before re-arbitration (0 allowed).
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_DONE (used only with the optional feature).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  level request per source; held high while the source has a frame pending.
- grant  out  NUM_REQ  one-hot grant; all zero when nothing is granted.
- tx_sel  out  $clog2(NUM_REQ)  index of the granted source.
- tx_start  out  1  single-cycle start pulse to the TX path.
- tx_done  in  1  single-cycle pulse from the TX path at frame end.
- tx_busy  out  1  high from grant through the end of the gap.
- timeout_err  out  1  single-cycle pulse on watchdog expiry; tied 0 without the optional feature.

Behaviour:
- Reset (aresetn=0 at a clock edge) values:
  - state=IDLE, grant=0, tx_sel=0, tx_start=0, tx_busy=0, timeout_err=0.
  - rr_ptr=0, gap counter=0, watchdog counter=0.
  - Reset mid-frame drops the grant immediately. No tx_start is replayed.
- All outputs are registered.
- States:
  - IDLE:
    - If req!=0, search indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first set bit wins (k).
    - At the next edge: grant=1<<k, tx_sel=k, tx_start=1, tx_busy=1, state=WAIT_DONE.
    - If req==0, stay in IDLE.
  - WAIT_DONE:
    - tx_start=0 (pulse is exactly one cycle, in the first WAIT_DONE cycle).
    - grant and tx_sel are held regardless of req changes; a source dropping req does not cancel its frame.
    - On tx_done=1: grant=0, rr_ptr=(k+1) mod NUM_REQ.
      - If IFG_CYCLES>0, go to GAP with the counter loaded to IFG_CYCLES-1.
      - Otherwise go to IDLE with tx_busy=0.
  - GAP:
    - grant=0, tx_busy=1.
    - Counter decrements each cycle; when it reaches 0, go to IDLE and set tx_busy=0.
    - This gives exactly IFG_CYCLES cycles in GAP.
- Latency:
  - req rising in IDLE at cycle N gives grant and tx_start at cycle N+1.
  - The minimum spacing between tx_start pulses is frame length + IFG_CYCLES + 2.
- Boundaries:
  - tx_done is sampled only in WAIT_DONE; it is ignored in IDLE and GAP and has no effect.
  - tx_done in the same cycle as tx_start (first WAIT_DONE cycle) is accepted as frame end.
  - All requesters active: service order is 0,1,2,0,1,2...
  - Single requester continuously active: it is re-granted after every gap.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Requests arriving during WAIT_DONE/GAP are not lost (level semantics) and are arbitrated on return to IDLE.
  - Grant is always one-hot or zero; tx_sel always matches the grant bit while the grant is non-zero.

Optional Feature:
- Macro: ETH_TX_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYCLES without tx_done: timeout_err=1 for one cycle, grant=0, rr_ptr advanced past k, and normal gap handling (GAP or IDLE) as for tx_done.
  - tx_done in the same cycle as expiry wins; no timeout_err is raised.
- Not defined:
  - No counter is implemented; WAIT_DONE waits indefinitely.
  - timeout_err is constant 0.

Test Plan:
- Reset then idle: aresetn low 2 cycles, req=000 for 20 cycles -> grant=000, tx_start never 1, tx_busy=0.
- Single request: req=010 at cycle N; tx_done 30 cycles after tx_start -> grant=010, tx_sel=1, tx_start pulse at N+1 only; after done, tx_busy stays high 12 cycles, then drops.
- Fairness: req=111 held, each frame done after 5 cycles -> grant sequence 001,010,100,001,010,100; tx_start pulses spaced 19 cycles apart.
- Request drop and spurious done: grant src0, drop req[0] mid-frame, pulse tx_done during GAP -> grant held until the real tx_done; the GAP-cycle tx_done is ignored; no extra tx_start.
- Reset mid-frame: aresetn low during WAIT_DONE with req=100 -> next cycle grant=000, tx_busy=0; after release, src2 is granted first only if it is the first set bit from rr_ptr=0 (req=100 -> grant=100).
- ETH_TX_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: grant src0, never assert tx_done -> timeout_err pulses once 16 cycles after entering WAIT_DONE, grant=000, next grant goes to src1 when req=011.
